// File: rtl/btn_conditioner.sv
// Push-button conditioning for the pong game top.
// Each raw button is brought into the clk domain through a two-flop chain,
// debounced, and turned into a clean level plus one-cycle press, release and
// auto-repeat pulses. All bits are handled independently with no priority.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             btn_any
);

  // Terminal counts. Each counter restarts at zero on its terminal value,
  // so a CNT_W-bit counter never wraps.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // Auto-repeat phase: waiting out the long initial delay, or the short period.
  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_e;

  // Synchroniser chain.
  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;

  // Debounced level and its one-cycle-delayed copy for edge detection.
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] level_dly_q, level_dly_d;

  // Registered pulse outputs.
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;

  // Per-button counters and repeat phase.
  logic [CNT_W-1:0] dcnt_q [N_BTN];
  logic [CNT_W-1:0] dcnt_d [N_BTN];
  logic [CNT_W-1:0] rcnt_q [N_BTN];
  logic [CNT_W-1:0] rcnt_d [N_BTN];
  phase_e           phase_q [N_BTN];
  phase_e           phase_d [N_BTN];

  // Next-state logic: synchronise, debounce, detect edges, schedule repeats.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    s1_d        = btn_in;
    s2_d        = s1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    release_d   = ~level_q & level_dly_q;
    repeat_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_d[i]  = dcnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      phase_d[i] = phase_q[i];

      // Debounce: the level only follows s2 after DEBOUNCE_CYCLES
      // consecutive disagreeing samples; any agreement restarts the count.
      if (s2_q[i] == level_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DEB_LAST) begin
        level_d[i] = s2_q[i];
        dcnt_d[i]  = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + ONE;
      end

      // Auto-repeat: the press itself is the first repeat pulse, then one
      // after the initial delay, then one every period while still held.
      if (press_d[i]) begin
        repeat_d[i] = 1'b1;
        rcnt_d[i]   = '0;
        phase_d[i]  = PH_DELAY;
      end else if (level_q[i]) begin
        if (phase_q[i] == PH_DELAY && rcnt_q[i] == DLY_LAST) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = '0;
          phase_d[i]  = PH_PERIOD;
        end else if (phase_q[i] == PH_PERIOD && rcnt_q[i] == PER_LAST) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = '0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + ONE;
        end
      end else begin
        rcnt_d[i]  = '0;
        phase_d[i] = PH_DELAY;
      end
    end
  end

  // State registers; everything clears asynchronously on reset.
  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of code order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      // NOTE: the counter arrays are real flops, not RAM, and must be
      // cleared so a reset mid-count discards any partial count.
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        phase_q[i] <= PH_DELAY;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign btn_any     = |level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short timing parameters.
// A sample-history model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations at key cycles.
module tb_btn_conditioner;

  localparam int NB   = 5;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int CW   = 8;
  localparam int HMAX = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic          btn_any;

  int checks   = 0;
  int failures = 0;

  btn_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .btn_any(btn_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[b][n]: raw input sampled at edge n after reset release.
  // mlev[b][n]: debounced level after edge n. Level flips at edge n when the
  // twice-delayed samples seen on the last D compares all disagree with it.
  int            n;
  bit            hist [NB][HMAX];
  bit            mlev [NB][HMAX];
  int            p_last [NB];
  logic [NB-1:0] exp_level, exp_press, exp_release, exp_repeat;

  function automatic bit h_at(int b, int j);
    return (j < 1) ? 1'b0 : hist[b][j];
  endfunction

  function automatic bit l_at(int b, int j);
    return (j < 0) ? 1'b0 : mlev[b][j];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0;
      for (int b = 0; b < NB; b++) begin
        p_last[b]  = -1;
        mlev[b][0] = 1'b0;
      end
      exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
    end else begin
      n = n + 1;
      if (n >= HMAX) begin
        $display("FAIL model_depth: got %0d expected below %0d", n, HMAX);
        $fatal(1, "model history exhausted");
      end
      for (int b = 0; b < NB; b++) begin
        bit flip;
        bit prs;
        hist[b][n] = btn_in[b];
        flip = 1'b1;
        for (int j = n - D - 1; j <= n - 2; j++)
          if (h_at(b, j) == l_at(b, n - 1)) flip = 1'b0;
        mlev[b][n] = flip ? ~l_at(b, n - 1) : l_at(b, n - 1);
        prs = l_at(b, n - 1) & ~l_at(b, n - 2);
        if (prs) p_last[b] = n;
        exp_level[b]   = mlev[b][n];
        exp_press[b]   = prs;
        exp_release[b] = ~l_at(b, n - 1) & l_at(b, n - 2);
        exp_repeat[b]  = prs || (p_last[b] >= 0 && l_at(b, n - 1) &&
                         (n - p_last[b]) >= RD && ((n - p_last[b] - RD) % RP) == 0);
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_level",   32'(btn_level),   32'd0);
      check("rst_press",   32'(btn_press),   32'd0);
      check("rst_release", 32'(btn_release), 32'd0);
      check("rst_repeat",  32'(btn_repeat),  32'd0);
      check("rst_any",     32'(btn_any),     32'd0);
    end else begin
      check("model_level",   32'(btn_level),   32'(exp_level));
      check("model_press",   32'(btn_press),   32'(exp_press));
      check("model_release", 32'(btn_release), 32'(exp_release));
      check("model_repeat",  32'(btn_repeat),  32'(exp_repeat));
      check("model_any",     32'(btn_any),     32'(|exp_level));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle(input int cycles);
    btn_in = '0;
    repeat (cycles) step();
  endtask

  initial begin
    int cnt_p, cnt_r, cnt_rep, first_p, last_rep, rel_edge;
    int rep_edge [3];
    logic [NB-1:0] acc;
    logic pat [5];

    btn_in = '0;
    reset  = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("first_cycle_after_reset", 32'({btn_level, btn_press, btn_repeat}), 32'd0);

    // Clean press on bit 0: level at edge 5, press/repeat after edge 6.
    btn_in[0] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == 4) check("t1_level_before", 32'(btn_level), 32'd0);
      if (e == 5) begin
        check("t1_level_rise", 32'(btn_level), 32'b00001);
        check("t1_press_not_yet", 32'(btn_press), 32'd0);
      end
      if (e == 6) begin
        check("t1_press", 32'(btn_press), 32'b00001);
        check("t1_repeat", 32'(btn_repeat), 32'b00001);
      end
      if (e == 7) check("t1_press_one_cycle", 32'(btn_press), 32'd0);
    end
    settle(15);

    // Glitch of 3 samples on bit 2 must never reach the level.
    acc = '0;
    for (int e = 0; e < 15; e++) begin
      btn_in[2] = (e < 3);
      step();
      acc = acc | btn_level | btn_press | btn_release;
    end
    check("t2_glitch_rejected", 32'(acc[2]), 32'd0);
    settle(5);

    // Bounce on bit 4: final rise sampled at edge 4 -> press at edge 4+D+2.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cnt_p = 0; first_p = -1;
    for (int e = 0; e < 20; e++) begin
      if (e < 5) btn_in[4] = pat[e];
      step();
      if (btn_press[4]) begin
        cnt_p++;
        if (first_p < 0) first_p = e;
      end
    end
    check("t3_bounce_press_count", 32'(cnt_p), 32'd1);
    check("t3_bounce_press_edge", 32'(first_p), 32'd10);
    settle(15);

    // Auto-repeat on bit 1: held for edges 0..39, released before edge 40.
    cnt_p = 0; cnt_r = 0; cnt_rep = 0; last_rep = -1; rel_edge = -1;
    rep_edge = '{-1, -1, -1};
    for (int e = 0; e < 55; e++) begin
      if (e == 0)  btn_in[1] = 1'b1;
      if (e == 40) btn_in[1] = 1'b0;
      step();
      if (btn_press[1]) cnt_p++;
      if (btn_release[1]) begin
        cnt_r++;
        rel_edge = e;
      end
      if (btn_repeat[1]) begin
        if (cnt_rep < 3) rep_edge[cnt_rep] = e;
        cnt_rep++;
        last_rep = e;
      end
    end
    check("t4_press_count", 32'(cnt_p), 32'd1);
    check("t4_first_repeat_at_press", 32'(rep_edge[0]), 32'd6);
    check("t4_second_repeat_delay", 32'(rep_edge[1]), 32'd16);
    check("t4_third_repeat_period", 32'(rep_edge[2]), 32'd19);
    check("t4_last_repeat", 32'(last_rep), 32'd43);
    check("t4_repeat_count", 32'(cnt_rep), 32'd11);
    check("t4_release_count", 32'(cnt_r), 32'd1);
    check("t4_release_edge", 32'(rel_edge), 32'd46);
    settle(10);

    // Simultaneous presses on bits 0 and 3.
    for (int e = 0; e < 10; e++) begin
      if (e == 0) btn_in = 5'b01001;
      step();
      if (e == 4) check("t5_any_before", 32'(btn_any), 32'd0);
      if (e == 5) begin
        check("t5_levels", 32'(btn_level), 32'b01001);
        check("t5_any_with_level", 32'(btn_any), 32'd1);
      end
      if (e == 6) check("t5_press_both", 32'(btn_press), 32'b01001);
    end
    settle(15);

    // Reset mid-count: bit 1 already debounced high, bit 0 counting (dcnt=2).
    btn_in[1] = 1'b1;
    repeat (10) step();
    check("t6_pre_level", 32'(btn_level), 32'b00010);
    btn_in[0] = 1'b1;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    check("t6_async_level", 32'(btn_level), 32'd0);
    check("t6_async_any", 32'(btn_any), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    for (int e = 1; e < 10; e++) begin
      step();
      if (e == 6) check("t6_press_not_yet", 32'(btn_press), 32'd0);
      if (e == 7) check("t6_press_after_reset", 32'(btn_press), 32'b00011);
    end
    settle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
